// File: rtl/playseq_preview_controller.sv
// PlaySeq preview sequencer: walks the sequence RAM from address 0 to the latched limit,
// showing each pattern for T_ACESO cycles followed by a T_APAGADO dark gap.
module playseq_preview_controller #(
  parameter int T_ACESO   = 500,
  parameter int T_APAGADO = 250,
  parameter int W_TIMER   = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [3:0] limite,
  input  logic [3:0] dado_memoria,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO  = 4'h0,
    CARREGA = 4'h1,
    ACESO   = 4'h2,
    APAGADO = 4'h3,
    FIM     = 4'hF
  } state_t;

  localparam logic [W_TIMER-1:0] ACESO_LAST   = W_TIMER'(T_ACESO - 1);
  localparam logic [W_TIMER-1:0] APAGADO_LAST = W_TIMER'(T_APAGADO - 1);

  state_t               state, state_n;
  logic [3:0]           endereco_n, leds_n, lim_reg, lim_n;
  logic [W_TIMER-1:0]   timer, timer_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= OCIOSO;
      endereco <= '0;
      leds     <= '0;
      timer    <= '0;
      lim_reg  <= '0;
    end else begin
      state    <= state_n;
      endereco <= endereco_n;
      leds     <= leds_n;
      timer    <= timer_n;
      lim_reg  <= lim_n;
    end
  end

  always_comb begin
    state_n    = state;
    endereco_n = endereco;
    leds_n     = leds;
    timer_n    = timer;
    lim_n      = lim_reg;
    case (state)
      OCIOSO: begin
        leds_n = '0;
        if (iniciar) begin
          lim_n      = limite;
          endereco_n = '0;
          timer_n    = '0;
          state_n    = CARREGA;
        end
      end
      // One cycle spent here lets the RAM settle on the new address.
      CARREGA: begin
        leds_n  = dado_memoria;
        timer_n = '0;
        state_n = ACESO;
      end
      ACESO: begin
        if (timer == ACESO_LAST) begin
          leds_n  = '0;
          timer_n = '0;
          state_n = APAGADO;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      APAGADO: begin
        if (timer == APAGADO_LAST) begin
          timer_n = '0;
          if (endereco == lim_reg) begin
            state_n = FIM;
          end else begin
            endereco_n = endereco + 1'b1;
            state_n    = CARREGA;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      FIM:     state_n = OCIOSO;
      default: state_n = OCIOSO;
    endcase

    // Abort overrides everything; in OCIOSO it only suppresses a simultaneous start.
    if (abortar) begin
      state_n = OCIOSO;
      leds_n  = '0;
      lim_n   = lim_reg;
      if (state != OCIOSO) begin
        endereco_n = '0;
        timer_n    = '0;
      end else begin
        endereco_n = endereco;
        timer_n    = timer;
      end
    end
  end

  assign pronto    = (state == FIM);
  assign ocupado   = (state != OCIOSO);
  assign db_estado = state;

endmodule

// File: tb/tb_playseq_preview_controller.sv
// Bench for the preview sequencer: table of preview runs checked cycle-by-cycle
// against a timing-formula scoreboard, plus abort/reset/held-start sequences.
module tb_playseq_preview_controller;
  localparam int TA  = 3;
  localparam int TP  = 2;
  localparam int PER = 1 + TA + TP;

  logic       clock = 1'b0;
  logic       reset, iniciar, abortar;
  logic [3:0] limite, dado_memoria, endereco, leds, db_estado;
  logic       ocupado, pronto;
  logic [3:0] ram [16];

  assign dado_memoria = ram[endereco];
  always #5 clock = ~clock;

  playseq_preview_controller #(.T_ACESO(TA), .T_APAGADO(TP), .W_TIMER(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
    .limite(limite), .dado_memoria(dado_memoria), .endereco(endereco),
    .leds(leds), .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  typedef struct {
    logic [3:0] st, led, adr;
    logic       pr, oc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int               lim;
    logic [15:0][3:0] mem;
    int               exp_pr;
    int               exp_lit;
  } vec_t;

  task automatic load_ram(input logic [15:0][3:0] mem);
    for (int i = 0; i < 16; i++) ram[i] = mem[i];
  endtask

  task automatic start(input int lim);
    limite  = 4'(lim);
    iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
  endtask

  // Called just after the edge that sampled iniciar. Expected cycle k behaviour
  // comes from the slot arithmetic: each position is 1 load + TA lit + TP dark.
  task automatic run_check(input int lim, input int chg_cyc, input logic [3:0] chg_lim,
                           output int pr_cyc, output int lit);
    int   last;
    int   p, o;
    exp_t e;
    last = (lim + 1) * PER;
    for (int k = 1; k <= last + 2; k++) begin
      if (k <= last) begin
        p = (k - 1) / PER;
        o = (k - 1) % PER;
        e.st  = (o == 0) ? 4'h1 : (o <= TA) ? 4'h2 : 4'h3;
        e.led = (o >= 1 && o <= TA) ? ram[p] : 4'h0;
        e.adr = 4'(p);
        e.pr  = 1'b0;
        e.oc  = 1'b1;
      end else begin
        e.st  = (k == last + 1) ? 4'hF : 4'h0;
        e.led = 4'h0;
        e.adr = 4'(lim);
        e.pr  = (k == last + 1);
        e.oc  = (k == last + 1);
      end
      sb.push_back(e);
    end
    pr_cyc = -1;
    lit = 0;
    for (int k = 1; k <= last + 2; k++) begin
      @(negedge clock);
      if (pronto && pr_cyc < 0) pr_cyc = k;
      if (leds != 0) lit++;
      e = sb.pop_front();
      chk($sformatf("c%0d_estado", k), db_estado, e.st);
      chk($sformatf("c%0d_leds", k), leds, e.led);
      chk($sformatf("c%0d_endereco", k), endereco, e.adr);
      chk($sformatf("c%0d_pronto", k), pronto, e.pr);
      chk($sformatf("c%0d_ocupado", k), ocupado, e.oc);
      if (k == chg_cyc) limite = chg_lim;
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_estado"}, db_estado, 0);
    chk({nm, "_leds"}, leds, 0);
    chk({nm, "_endereco"}, endereco, 0);
    chk({nm, "_ocupado"}, ocupado, 0);
    chk({nm, "_pronto"}, pronto, 0);
  endtask

  initial begin
    vec_t vecs[5];
    int   pr, lit, seen;
    vecs[0] = '{1,  64'h0000_0000_0000_8421, 13, 6};
    vecs[1] = '{0,  64'h0000_0000_0000_0004, 7,  3};
    vecs[2] = '{15, 64'hFEDC_BA98_7654_3219, 97, 48};
    vecs[3] = '{0,  64'hFFFF_FFFF_FFFF_FFF0, 7,  0};
    vecs[4] = '{3,  64'h0000_0000_0000_5030, 25, 6};

    reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; limite = 4'h0;
    for (int i = 0; i < 16; i++) ram[i] = 4'h0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk_idle("reset");

    for (int i = 0; i < 5; i++) begin
      load_ram(vecs[i].mem);
      start(vecs[i].lim);
      run_check(vecs[i].lim, 0, 4'h0, pr, lit);
      chk($sformatf("v%0d_pronto_cycle", i), pr, vecs[i].exp_pr);
      chk($sformatf("v%0d_lit_cycles", i), lit, vecs[i].exp_lit);
    end

    // Abort during the lit slot of position 1, then a clean restart.
    load_ram(64'h0000_0000_0000_8421);
    start(3);
    repeat (7) @(posedge clock);
    #1 abortar = 1'b1;
    @(negedge clock);
    chk("abort_pre_estado", db_estado, 2);
    chk("abort_pre_endereco", endereco, 1);
    @(posedge clock);
    #1 abortar = 1'b0;
    @(negedge clock);
    chk_idle("abort");
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (pronto || ocupado) seen++;
    end
    chk("abort_quiet", seen, 0);
    start(1);
    run_check(1, 0, 4'h0, pr, lit);
    chk("restart_pronto_cycle", pr, 13);

    // Start held high with a limit change mid-run: the change must not leak in.
    load_ram(64'h0000_0000_0021_8421);
    limite  = 4'h1;
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    run_check(1, 4, 4'h5, pr, lit);
    chk("held_pronto_cycle", pr, 13);
    @(posedge clock);
    #1 iniciar = 1'b0;
    run_check(5, 0, 4'h0, pr, lit);
    chk("held_restart_pronto_cycle", pr, 37);

    // Reset during the dark gap.
    start(2);
    repeat (4) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_pre_estado", db_estado, 3);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk_idle("rst_mid");

    // Reset together with start, then abort together with start.
    reset = 1'b1; iniciar = 1'b1; limite = 4'h2;
    @(posedge clock);
    #1 reset = 1'b0; iniciar = 1'b0;
    @(negedge clock);
    chk("rst_start_estado", db_estado, 0);
    chk("rst_start_ocupado", ocupado, 0);
    abortar = 1'b1; iniciar = 1'b1;
    @(posedge clock);
    #1 abortar = 1'b0; iniciar = 1'b0;
    @(negedge clock);
    chk("abort_start_estado", db_estado, 0);
    chk("abort_start_ocupado", ocupado, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
